toccata_capture: RTL and testbench

Record path of the Toccata sound card: takes codec ADC sample frames at the sample rate, formats them into the byte stream the Amiga driver expects and buffers them in a capture FIFO drained by CPU reads. Raises a one-cycle half_full pulse for the record interrupt, with hysteresis so reads and writes landing close together cannot retrigger it. Sits between the codec serial-interface receiver and the Zorro register block.

---
 rtl/toccata_pkg.sv | 45 ++++
 rtl/toccata_capture_fifo.sv | 94 +++++++++
 rtl/toccata_capture.sv | 195 +++++++++++++++++++
 tb/tb_toccata_capture.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toccata_pkg.sv
// Shared types and helpers for the Toccata record path: packer states,
// sample format encoding and the byte ordering of a captured frame.
package toccata_pkg;

    typedef enum logic [0:0] {
        PK_IDLE = 1'b0,
        PK_PUSH = 1'b1
    } pack_state_e;

    typedef struct packed {
        logic is_16bit;
        logic is_stereo;
    } fmt_t;

    localparam logic [7:0] SIGN_FLIP = 8'h80;

    function automatic logic [2:0] frame_len(input fmt_t fmt);
        logic [2:0] len;
        case ({fmt.is_16bit, fmt.is_stereo})
            2'b00:   len = 3'd1;
            2'b01:   len = 3'd2;
            2'b10:   len = 3'd2;
            2'b11:   len = 3'd4;
            default: len = 3'd1;
        endcase
        return len;
    endfunction

    // 16-bit frames go out little-endian L then R; 8-bit frames carry only
    // the high byte of each sample, converted to offset binary.
    function automatic logic [7:0] frame_byte(input fmt_t fmt, input logic [15:0] left,
                                              input logic [15:0] right, input logic [1:0] idx);
        logic [15:0] smp;
        logic [7:0]  b;
        if (fmt.is_16bit) begin
            smp = idx[1] ? right : left;
            b   = idx[0] ? smp[15:8] : smp[7:0];
        end else begin
            smp = idx[0] ? right : left;
            b   = smp[15:8] ^ SIGN_FLIP;
        end
        return b;
    endfunction

endpackage

// File: rtl/toccata_capture_fifo.sv
// Single-clock byte FIFO for the capture path: RAM without reset, wrapping
// pointers, registered count/empty/full and a registered read port.
module toccata_capture_fifo #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [7:0]               i_wr_data,
    input  logic                     i_rd_en,
    output logic [7:0]               o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_empty;
    logic          r_full;
    logic [7:0]    r_rd_data;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [AW:0]   w_count_next;

    assign w_wr_ok = i_wr_en && !r_full;
    assign w_rd_ok = i_rd_en && !r_empty;

    // Occupancy after this cycle's write and read
    always_comb begin
        w_count_next = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // RAM write port; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (w_wr_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, occupancy and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= CNT_ZERO;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= CNT_ZERO;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= w_count_next;
            r_empty <= (w_count_next == CNT_ZERO);
            r_full  <= (w_count_next == CNT_FULL);
        end
    end

    // Registered read data; holds when no byte is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 8'h00;
        end else if (i_flush) begin
            r_rd_data <= 8'h00;
        end else if (w_rd_ok) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_count   = r_count;
    assign o_empty   = r_empty;
    assign o_full    = r_full;

endmodule

// File: rtl/toccata_capture.sv
// Toccata record path: packs codec frames into driver byte order, buffers
// them for CPU reads and raises the half-full record interrupt pulse.
module toccata_capture
    import toccata_pkg::*;
#(
    parameter int FIFO_DEPTH = 1024,
    parameter int HYST       = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          fmt_16bit,
    input  logic                          fmt_stereo,
    input  logic                          smp_valid,
    input  logic [15:0]                   smp_left,
    input  logic [15:0]                   smp_right,
    input  logic                          rd_en,
    output logic [7:0]                    data_out,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          half_full,
    output logic                          overrun,
    input  logic                          ovr_clr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'(FIFO_DEPTH / 2);
    localparam logic [CW-1:0] REARM_C = CW'(FIFO_DEPTH / 2 - HYST);

    pack_state_e   r_state;
    pack_state_e   w_state_next;
    fmt_t          r_fmt;
    fmt_t          w_fmt_in;
    logic [15:0]   r_left;
    logic [15:0]   r_right;
    logic [1:0]    r_idx;
    logic [2:0]    w_len_in;
    logic [2:0]    w_len_cur;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_space;
    logic          w_space_ok;
    logic          w_last;
    logic          w_accept;
    logic          w_drop;
    logic          w_wr_en;
    logic [7:0]    w_wr_data;
    logic          r_overrun;
    logic          r_armed;
    logic          r_half_full;
    logic [CW-1:0] r_count_d;
    logic          w_hf_fire;

    assign w_fmt_in  = {fmt_16bit, fmt_stereo};
    assign w_len_in  = frame_len(w_fmt_in);
    assign w_len_cur = frame_len(r_fmt);
    // Only checked in IDLE, where no accepted bytes are still outstanding
    assign w_space    = DEPTH_C - w_count;
    assign w_space_ok = (w_space >= {{(CW-3){1'b0}}, w_len_in});
    assign w_last     = ({1'b0, r_idx} == (w_len_cur - 3'd1));

    // Packer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PK_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Packer next-state logic
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = PK_IDLE;
        end else begin
            case (r_state)
                PK_IDLE: w_state_next = w_accept ? PK_PUSH : PK_IDLE;
                PK_PUSH: w_state_next = w_last ? PK_IDLE : PK_PUSH;
                default: w_state_next = PK_IDLE;
            endcase
        end
    end

    // Packer outputs: accept/drop decisions and the FIFO write port
    always_comb begin
        w_accept  = 1'b0;
        w_drop    = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_data = frame_byte(r_fmt, r_left, r_right, r_idx);
        if (flush) begin
            w_accept = 1'b0;
            w_drop   = 1'b0;
            w_wr_en  = 1'b0;
        end else begin
            case (r_state)
                PK_IDLE: begin
                    if (smp_valid && enable) begin
                        w_accept = w_space_ok;
                        w_drop   = !w_space_ok;
                    end else begin
                        w_accept = 1'b0;
                        w_drop   = 1'b0;
                    end
                end
                PK_PUSH: begin
                    w_wr_en = 1'b1;
                    w_drop  = smp_valid;
                end
                default: begin
                    w_accept = 1'b0;
                    w_drop   = 1'b0;
                    w_wr_en  = 1'b0;
                end
            endcase
        end
    end

    // Latched frame and byte index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fmt   <= '{is_16bit: 1'b0, is_stereo: 1'b0};
            r_left  <= 16'h0000;
            r_right <= 16'h0000;
            r_idx   <= 2'd0;
        end else if (flush) begin
            r_idx <= 2'd0;
        end else if (w_accept) begin
            r_fmt   <= w_fmt_in;
            r_left  <= smp_left;
            r_right <= smp_right;
            r_idx   <= 2'd0;
        end else if (r_state == PK_PUSH) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Sticky overrun; a drop on the clear cycle keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (flush) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign w_hf_fire = r_armed && (w_count == HALF_C) && (r_count_d != HALF_C);

    // Half-full pulse with re-arm hysteresis
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed     <= 1'b1;
            r_half_full <= 1'b0;
            r_count_d   <= {CW{1'b0}};
        end else if (flush) begin
            r_armed     <= 1'b1;
            r_half_full <= 1'b0;
            r_count_d   <= {CW{1'b0}};
        end else begin
            r_count_d   <= w_count;
            r_half_full <= w_hf_fire;
            if (w_hf_fire) begin
                r_armed <= 1'b0;
            end else if (w_count <= REARM_C) begin
                r_armed <= 1'b1;
            end
        end
    end

    toccata_capture_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (flush),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (rd_en),
        .o_rd_data (data_out),
        .o_count   (w_count),
        .o_empty   (empty),
        .o_full    (full)
    );

    assign count     = w_count;
    assign overrun   = r_overrun;
    assign half_full = r_half_full;

endmodule

// File: tb/tb_toccata_capture.sv
// Scoreboard bench for toccata_capture: expected bytes are queued as frames
// are driven and popped as the CPU side reads them back.
module tb_toccata_capture;

    localparam int DEPTH = 1024;
    localparam int HYST  = 8;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic        fmt_16bit;
    logic        fmt_stereo;
    logic        smp_valid;
    logic [15:0] smp_left;
    logic [15:0] smp_right;
    logic        rd_en;
    logic [7:0]  data_out;
    logic        empty;
    logic        full;
    logic [10:0] count;
    logic        half_full;
    logic        overrun;
    logic        ovr_clr;

    int         n_cmp;
    int         n_bad;
    logic [7:0] exp_q[$];
    int         mcount;
    logic       movr;
    logic [7:0] mlast;
    int         hf_cnt;
    logic       hf_prev;
    logic       hf_wide;

    toccata_capture #(.FIFO_DEPTH(DEPTH), .HYST(HYST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .flush      (flush),
        .fmt_16bit  (fmt_16bit),
        .fmt_stereo (fmt_stereo),
        .smp_valid  (smp_valid),
        .smp_left   (smp_left),
        .smp_right  (smp_right),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .half_full  (half_full),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count interrupt pulses and catch any pulse longer than one cycle
    always @(negedge clk) begin
        if (half_full === 1'b1) begin
            hf_cnt <= hf_cnt + 1;
            if (hf_prev) hf_wide <= 1'b1;
        end
        hf_prev <= (half_full === 1'b1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int frame_n(input logic b16, input logic st);
        return (b16 ? 2 : 1) * (st ? 2 : 1);
    endfunction

    function automatic void model_frame(input logic [15:0] l, input logic [15:0] r,
                                        input logic b16, input logic st);
        if (b16) begin
            exp_q.push_back(l[7:0]);
            exp_q.push_back(l[15:8]);
            if (st) begin
                exp_q.push_back(r[7:0]);
                exp_q.push_back(r[15:8]);
            end
        end else begin
            exp_q.push_back(l[15:8] + 8'h80);
            if (st) exp_q.push_back(r[15:8] + 8'h80);
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        mcount = 0;
        movr   = 1'b0;
        mlast  = 8'h00;
    endfunction

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r,
                              input logic b16, input logic st);
        int n;
        n = frame_n(b16, st);
        fmt_16bit  = b16;
        fmt_stereo = st;
        smp_left   = l;
        smp_right  = r;
        smp_valid  = 1'b1;
        tick();
        smp_valid = 1'b0;
        if (enable && (mcount + n <= DEPTH)) begin
            model_frame(l, r, b16, st);
            mcount += n;
            repeat (n) tick();
        end else if (enable) begin
            movr = 1'b1;
        end
    endtask

    task automatic read_byte();
        logic [7:0] exp;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (mcount > 0) begin
            exp    = exp_q.pop_front();
            mcount -= 1;
            mlast  = exp;
        end else begin
            exp = mlast;
        end
        n_cmp++;
        if (data_out !== exp) begin
            n_bad++;
            $display("FAIL read_byte: data_out=%02h expected=%02h", data_out, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; flush = 1'b0; fmt_16bit = 1'b0; fmt_stereo = 1'b0;
        smp_valid = 1'b0; smp_left = 16'h0000; smp_right = 16'h0000; rd_en = 1'b0; ovr_clr = 1'b0;
        model_clear();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %02h want 00", data_out); end
        n_cmp++; if (count !== 11'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (half_full !== 1'b0) begin n_bad++; $display("FAIL reset_hf: got %b want 0", half_full); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    endtask

    task automatic test_16s();
        fmt_16bit = 1'b1; fmt_stereo = 1'b1;
        smp_left = 16'h1234; smp_right = 16'hABCD; smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
        model_frame(16'h1234, 16'hABCD, 1'b1, 1'b1);
        mcount = 4;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (count !== 11'(i)) begin n_bad++; $display("FAIL s16_push_cycle: count=%0d want %0d", count, i); end
        end
        tick();
        n_cmp++; if (count !== 11'd4) begin n_bad++; $display("FAIL s16_no_extra: count=%0d want 4", count); end
        repeat (4) read_byte();
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL s16_empty: got %b want 1", empty); end
    endtask

    task automatic test_formats();
        push_frame(16'h0000, 16'h0000, 1'b0, 1'b0);
        push_frame(16'h8000, 16'h0000, 1'b0, 1'b0);
        push_frame(16'h7F00, 16'hFF00, 1'b0, 1'b1);
        push_frame(16'hBEEF, 16'h5555, 1'b1, 1'b0);
        n_cmp++; if (count !== 11'd6) begin n_bad++; $display("FAIL fmt_count: count=%0d want 6", count); end
        repeat (6) read_byte();
    endtask

    task automatic test_half_full();
        int h0;
        h0 = hf_cnt;
        for (int i = 0; i < 128; i++)
            push_frame(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b1, 1'b1);
        repeat (2) tick();
        n_cmp++; if (count !== 11'd512) begin n_bad++; $display("FAIL hf_count512: count=%0d want 512", count); end
        n_cmp++; if (hf_cnt !== h0 + 1) begin n_bad++; $display("FAIL hf_first: pulses=%0d want %0d", hf_cnt - h0, 1); end
        repeat (2) read_byte();
        push_frame(16'h2200, 16'h3300, 1'b0, 1'b1);
        repeat (3) tick();
        n_cmp++; if (hf_cnt !== h0 + 1) begin n_bad++; $display("FAIL hf_hyst: pulses=%0d want %0d", hf_cnt - h0, 1); end
        repeat (8) read_byte();
        push_frame(16'h0102, 16'h0304, 1'b1, 1'b1);
        push_frame(16'h0506, 16'h0708, 1'b1, 1'b1);
        repeat (3) tick();
        n_cmp++; if (hf_cnt !== h0 + 2) begin n_bad++; $display("FAIL hf_rearm: pulses=%0d want %0d", hf_cnt - h0, 2); end
        n_cmp++; if (hf_wide !== 1'b0) begin n_bad++; $display("FAIL hf_width: wide=%b want 0", hf_wide); end
        repeat (512) read_byte();
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL hf_drain: empty=%b want 1", empty); end
    endtask

    task automatic test_overrun_full();
        for (int i = 0; i < 255; i++)
            push_frame(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b1, 1'b1);
        push_frame(16'hC3A5, 16'h0000, 1'b1, 1'b0);
        n_cmp++; if (count !== 11'd1022) begin n_bad++; $display("FAIL ovr_fill: count=%0d want 1022", count); end
        push_frame(16'hDEAD, 16'hBEEF, 1'b1, 1'b1);
        tick();
        n_cmp++; if (count !== 11'd1022) begin n_bad++; $display("FAIL ovr_dropcount: count=%0d want 1022", count); end
        n_cmp++; if (overrun !== movr) begin n_bad++; $display("FAIL ovr_set: overrun=%b want %b", overrun, movr); end
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; movr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clr: overrun=%b want 0", overrun); end
        repeat (2) read_byte();
        push_frame(16'h4321, 16'h8765, 1'b1, 1'b1);
        n_cmp++; if (count !== 11'd1024) begin n_bad++; $display("FAIL full_count: count=%0d want 1024", count); end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_flag: full=%b want 1", full); end
        push_frame(16'h1100, 16'h0000, 1'b0, 1'b0);
        tick();
        n_cmp++; if (overrun !== movr) begin n_bad++; $display("FAIL full_drop: overrun=%b want %b", overrun, movr); end
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; movr = 1'b0;
        repeat (1024) read_byte();
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL full_drain: empty=%b want 1", empty); end
        read_byte();
        n_cmp++; if (count !== 11'd0) begin n_bad++; $display("FAIL empty_read: count=%0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        fmt_16bit = 1'b1; fmt_stereo = 1'b1;
        smp_left = 16'h1111; smp_right = 16'h2222; smp_valid = 1'b1;
        tick();
        fmt_16bit = 1'b0; fmt_stereo = 1'b0;
        smp_left = 16'h3333; smp_right = 16'h4444;
        tick();
        smp_valid = 1'b0;
        model_frame(16'h1111, 16'h2222, 1'b1, 1'b1);
        mcount = 4;
        movr   = 1'b1;
        repeat (5) tick();
        n_cmp++; if (count !== 11'd4) begin n_bad++; $display("FAIL b2b_count: count=%0d want 4", count); end
        n_cmp++; if (overrun !== movr) begin n_bad++; $display("FAIL b2b_ovr: overrun=%b want %b", overrun, movr); end
        repeat (4) read_byte();
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; movr = 1'b0;
        fmt_16bit = 1'b0; fmt_stereo = 1'b0; smp_left = 16'h9A00; smp_valid = 1'b1;
        tick();
        model_frame(16'h9A00, 16'h0000, 1'b0, 1'b0);
        mcount = 1;
        ovr_clr = 1'b1; smp_left = 16'h7700;
        tick();
        smp_valid = 1'b0; ovr_clr = 1'b0; movr = 1'b1;
        tick();
        n_cmp++; if (overrun !== movr) begin n_bad++; $display("FAIL set_beats_clr: overrun=%b want %b", overrun, movr); end
        read_byte();
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; movr = 1'b0;
    endtask

    task automatic test_enable();
        fmt_16bit = 1'b1; fmt_stereo = 1'b1;
        smp_left = 16'hFACE; smp_right = 16'h0B0E; smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0; enable = 1'b0;
        model_frame(16'hFACE, 16'h0B0E, 1'b1, 1'b1);
        mcount = 4;
        repeat (4) tick();
        n_cmp++; if (count !== 11'd4) begin n_bad++; $display("FAIL en_complete: count=%0d want 4", count); end
        push_frame(16'h1357, 16'h2468, 1'b1, 1'b1);
        repeat (4) tick();
        n_cmp++; if (count !== 11'd4) begin n_bad++; $display("FAIL en_off_count: count=%0d want 4", count); end
        n_cmp++; if (overrun !== movr) begin n_bad++; $display("FAIL en_off_ovr: overrun=%b want %b", overrun, movr); end
        enable = 1'b1;
        repeat (4) read_byte();
    endtask

    task automatic test_reset_mid();
        fmt_16bit = 1'b1; fmt_stereo = 1'b1;
        smp_left = 16'h5A5A; smp_right = 16'hA5A5; smp_valid = 1'b1;
        tick();
        tick();
        smp_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        n_cmp++; if (count !== 11'd0) begin n_bad++; $display("FAIL rstmid_count: count=%0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_empty: empty=%b want 1", empty); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %02h want 00", data_out); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rstmid_ovr: overrun=%b want 0", overrun); end
        n_cmp++; if (full !== 1'b0 || half_full !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_flags: full=%b half_full=%b want 0 0", full, half_full);
        end
        #3;
        rst_n = 1'b1;
        repeat (5) tick();
        n_cmp++; if (count !== 11'd0) begin n_bad++; $display("FAIL rstmid_idle: count=%0d want 0", count); end
        push_frame(16'hC000, 16'h0000, 1'b0, 1'b0);
        read_byte();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 25; i++)
            push_frame(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b1, 1'b1);
        n_cmp++; if (count !== 11'd100) begin n_bad++; $display("FAIL flush_fill: count=%0d want 100", count); end
        flush = 1'b1; tick(); flush = 1'b0;
        model_clear();
        n_cmp++; if (count !== 11'd0) begin n_bad++; $display("FAIL flush_count: count=%0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL flush_empty: empty=%b want 1", empty); end
        fmt_16bit = 1'b1; fmt_stereo = 1'b1; smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (4) tick();
        n_cmp++; if (count !== 11'd0) begin n_bad++; $display("FAIL flush_midframe: count=%0d want 0", count); end
        push_frame(16'h3F00, 16'h0000, 1'b0, 1'b0);
        read_byte();
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        hf_cnt  = 0;
        hf_prev = 1'b0;
        hf_wide = 1'b0;
        test_reset();
        test_16s();
        test_formats();
        test_half_full();
        test_overrun_full();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
